// File: rtl/prewish_blinky.sv
// Blinks an 8-bit mask out on o_led, MSB first, TICK_DIV clocks per bit.
// A rising edge on STB_I loads a new mask. A mask of zero parks the block in IDLE.
module prewish_blinky #(
  parameter int TICK_DIV = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  output logic       ACK_O,
  output logic       o_led,
  output logic       o_cycle
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [7:0]       mask_q, mask_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stb_prev_q, stb_prev_d;
  logic             ack_q, ack_d;
  logic             cycle_q, cycle_d;
  logic             load;

  assign load = STB_I & ~stb_prev_q;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    stb_prev_d = STB_I;
    ack_d      = 1'b0;
    cycle_d    = 1'b0;

    // A load takes priority over the bit-advance, so a collision never pulses o_cycle.
    if (load) begin
      mask_d  = DAT_I;
      idx_d   = 3'd7;
      cnt_d   = '0;
      ack_d   = 1'b1;
      state_d = (DAT_I != 8'h00) ? ST_RUN : ST_IDLE;
    end else if (state_q == ST_RUN) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        idx_d   = idx_q - 3'd1;
        cycle_d = (idx_q == 3'd0);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // stb_prev resets high so a strobe held through reset release is not a load.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q    <= ST_IDLE;
      mask_q     <= 8'h00;
      idx_q      <= 3'd7;
      cnt_q      <= '0;
      stb_prev_q <= 1'b1;
      ack_q      <= 1'b0;
      cycle_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      stb_prev_q <= stb_prev_d;
      ack_q      <= ack_d;
      cycle_q    <= cycle_d;
    end
  end

  assign ACK_O   = ack_q;
  assign o_cycle = cycle_q;
  assign o_led   = (state_q == ST_RUN) & mask_q[idx_q];

endmodule

// File: tb/tb_prewish_blinky.sv
// Randomized and directed bench for prewish_blinky against an elapsed-time model:
// the expected LED is mask bit 7 - (t / TICK_DIV) mod 8, where t counts clocks since the last load.
module tb_prewish_blinky;

  localparam int TD = 4;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b0;
  logic       STB_I = 1'b0;
  logic [7:0] DAT_I = 8'h00;
  logic       ACK_O;
  logic       o_led;
  logic       o_cycle;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  bit       m_prev   = 1'b1;
  bit       m_active = 1'b0;
  bit       m_ack    = 1'b0;
  bit [7:0] m_mask   = 8'h00;
  int       m_t      = 0;
  int       n_loads  = 0;

  prewish_blinky #(.TICK_DIV(TD)) dut (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .STB_I  (STB_I),
    .DAT_I  (DAT_I),
    .ACK_O  (ACK_O),
    .o_led  (o_led),
    .o_cycle(o_cycle)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%b expected=%b (t=%0d mask=%h)", tag, $time, got, exp, m_t, m_mask);
    end
  endtask

  function automatic bit exp_led();
    bit [7:0] mk;
    int bit_no;
    mk = m_mask;
    bit_no = 7 - ((m_t / TD) % 8);
    return m_active && mk[bit_no];
  endfunction

  function automatic bit exp_cycle();
    return m_active && (m_t > 0) && (m_t % (8 * TD) == 0);
  endfunction

  task automatic model_reset();
    m_prev   = 1'b1;
    m_active = 1'b0;
    m_ack    = 1'b0;
    m_t      = 0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".led"},   o_led,   exp_led());
    chk({ctx, ".ack"},   ACK_O,   m_ack);
    chk({ctx, ".cycle"}, o_cycle, exp_cycle());
  endtask

  // Drive inputs, advance one clock, update the model, then check at the falling edge.
  task automatic step(input logic stb, input logic [7:0] dat, input string ctx);
    STB_I = stb;
    DAT_I = dat;
    @(posedge CLK_I);
    if (!RST_I) begin
      model_reset();
    end else if (stb && !m_prev) begin
      m_prev   = stb;
      m_mask   = dat;
      m_t      = 0;
      m_active = (dat != 8'h00);
      m_ack    = 1'b1;
      n_loads++;
    end else begin
      m_prev = stb;
      m_ack  = 1'b0;
      if (m_active) m_t++;
    end
    @(negedge CLK_I);
    check_outputs(ctx);
  endtask

  initial begin
    int ack_seen;

    // reset state
    #3;
    check_outputs("reset");
    @(negedge CLK_I);
    RST_I = 1'b1;

    // one-cycle load of 10110100: runs two full passes
    step(1'b1, 8'b1011_0100, "pat_load");
    for (int i = 0; i < 2 * 8 * TD + 3; i++) step(1'b0, 8'h00, "pattern");

    // zero load while 8'hAA runs
    step(1'b1, 8'hAA, "aa_load");
    for (int i = 0; i < 13; i++) step(1'b0, 8'h00, "aa_run");
    step(1'b1, 8'h00, "zero_load");
    for (int i = 0; i < 3 * 8 * TD; i++) step(1'b0, 8'h00, "zero_idle");

    // held strobe: exactly one ACK_O pulse
    ack_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h81, "held");
      ack_seen += int'(ACK_O);
    end
    n_checks++;
    if (ack_seen != 1) begin
      n_errors++;
      $display("FAIL held_ack_count: got=%0d expected=1", ack_seen);
    end
    for (int i = 0; i < 8 * TD + 2; i++) step(1'b0, 8'h00, "held_run");

    // collision: reload on the edge where cnt=3 and idx=0
    step(1'b1, 8'h0F, "coll_load");
    for (int i = 0; i < 8 * TD - 1; i++) step(1'b0, 8'h0F, "coll_pre");
    step(1'b1, 8'h0F, "coll_hit");
    chk("coll_led_zero", o_led, 1'b0);
    chk("coll_no_cycle", o_cycle, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, "coll_post");

    // async reset mid-pattern with 8'hFF
    step(1'b1, 8'hFF, "ff_load");
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, "ff_run");
    @(posedge CLK_I);
    m_t++;
    #2;
    RST_I = 1'b0;
    model_reset();
    #1;
    chk("async_rst.led",   o_led,   1'b0);
    chk("async_rst.ack",   ACK_O,   1'b0);
    chk("async_rst.cycle", o_cycle, 1'b0);
    step(1'b0, 8'h00, "in_reset");
    step(1'b1, 8'h55, "in_reset_stb");
    RST_I = 1'b1;
    for (int i = 0; i < 8 * TD + 4; i++) step(1'b0, 8'h00, "post_rst_idle");

    // reset release with STB_I held high
    RST_I = 1'b0;
    STB_I = 1'b1;
    #1;
    model_reset();
    step(1'b1, 8'hC3, "rel_in_reset");
    RST_I = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 8'hC3, "rel_held");
    step(1'b0, 8'hC3, "rel_low");
    step(1'b1, 8'hC3, "rel_load");
    chk("rel_ack", ACK_O, 1'b1);
    for (int i = 0; i < 8 * TD + 2; i++) step(1'b0, 8'h00, "rel_run");

    // randomized strobes, data and occasional held strobes
    for (int i = 0; i < 1500; i++) begin
      logic s;
      logic [7:0] d;
      s = ($urandom_range(0, 39) == 0) || (STB_I && $urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      step(s, d, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
